branch_resolution_queue: RTL and testbench
==========================================

# branch_resolution_queue

Tracks every branch prediction issued by fetch until execute resolves it, then produces the training update for `branch_target_buffer` and a fetch redirect on misprediction. Sits between fetch (which pushes the BTB's `pred`/`target` along with the branch PC) and execute (which pops with the actual outcome). Its `update_*` outputs drive the BTB's update port directly.

## Interface
- `DEPTH`, 4: in-flight branch entries; power of two, ≥2.
- `clk`  in  1  clock; all state changes on rising edge.
- `clear`  in  1  synchronous active-high reset.
- `push_valid`  in  1  fetch issues a branch this cycle.
- `push_pc`  in  32  branch PC.
- `push_pred`  in  1  BTB predicted taken.
- `push_target`  in  32  BTB predicted target.
- `full`  out  1  queue holds `DEPTH` entries; fetch must stall.
- `resolve_valid`  in  1  execute resolves the oldest in-flight branch.
- `resolve_taken`  in  1  actual outcome.
- `resolve_target`  in  32  actual computed target, valid even when not taken.
- `update_en`  out  1  BTB update strobe.
- `update_outcome`  out  1  actual outcome.
- `update_pc`  out  32  PC being trained.
- `update_target`  out  32  actual target.
- `mispredict`  out  1  one-cycle redirect pulse.
- `redirect_pc`  out  32  correct next PC; meaningful only with `mispredict`.
- `underflow`  out  1  sticky; resolve arrived with queue empty.

## Operation
- Circular FIFO: read pointer, write pointer, occupancy count of width $clog2(DEPTH)+1.
- Push is accepted iff `push_valid && !full`. A push while full is dropped and state is unchanged.
- Resolve pops the head entry. Mispredict is defined as `head.pred != resolve_taken || (resolve_taken && head.target != resolve_target)`.
- Redirect target is `resolve_taken ? resolve_target : head.pc + 4`, with 32-bit wrap (`32'hFFFF_FFFC` wraps to `0`).
- Every valid pop registers `update_en=1`, `update_outcome=resolve_taken`, `update_pc=head.pc`, `update_target=resolve_target`. This applies to correct predictions too.
- On mispredict, all entries are flushed (count, rptr and wptr go to 0). Any push in the same cycle is discarded as wrong-path.
- Push and pop in the same cycle with no mispredict: count is unchanged and both pointers advance. This is allowed when the queue is not full. When full, the push is rejected even if a pop occurs in the same cycle.
- Resolve with the queue empty: no pop, no update, no mispredict. `underflow` sets and holds until `clear`.
- `clear` resets pointers, count, all outputs and `underflow` to 0. Entry storage need not be cleared. `clear` overrides any push or resolve in the same cycle.

## Timing
- `full` is combinational from count. It reflects the state after the previous edge.
- `update_*`, `mispredict`, `redirect_pc` are registered and valid the cycle after the resolve edge (latency 1). Each is a single-cycle pulse and returns to 0 / holds its last value as listed below.
- `update_en` and `mispredict` are 0 in any cycle without a preceding valid pop.
- `update_pc`, `update_target` and `redirect_pc` hold their last value when not strobed.
- A push entry can be resolved no earlier than the cycle after the push edge. Same-edge push-and-pop of an empty queue is not a bypass: the resolve counts as underflow.
- Reset values: `full=0`, `update_en=0`, `update_outcome=0`, `update_pc=0`, `update_target=0`, `mispredict=0`, `redirect_pc=0`, `underflow=0`.

## Structure
- Package `bp_pkg`:
  - `localparam ADDR_W=32`, `INSTR_BYTES=4`.
  - `typedef struct packed {logic [31:0] pc; logic pred; logic [31:0] target;} pred_entry_t`.
  - Shared by fetch, BTB glue and this block.
- One sub-module, `pred_fifo`, is natural. It is a parameterised FIFO of `pred_entry_t` with push, pop, flush, full, empty and head.
- The top level holds compare, redirect computation and output registers.

## Test plan
- Clear, then push pc=0x100 pred=1 tgt=0x200, then resolve taken tgt=0x200 → next cycle: `update_en=1`, `update_pc=0x100`, `update_target=0x200`, `update_outcome=1`, `mispredict=0`.
- Push pc=0x40 pred=1 tgt=0x80, then resolve not taken → `mispredict=1`, `redirect_pc=0x44`, `update_outcome=0`. Queue is empty afterwards.
- Push pc=0x10 pred=1 tgt=0x20, then resolve taken tgt=0x30 → `mispredict=1`, `redirect_pc=0x30`.
- Push 4 branches (DEPTH=4) → `full=1` and a 5th push is dropped. Then perform 4 correct resolves → update_pc values in push order, and `full` drops after the first pop.
- Push A, B, C; mispredict on A in the same cycle as pushing D → B, C and D are flushed. A following resolve sets `underflow=1` with no `update_en`.
- Push pc=0xFFFF_FFFC pred=1, then resolve not taken → `redirect_pc=0x0000_0000`. Then assert `clear` mid-queue → all outputs 0 next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch-prediction types shared by fetch, the BTB glue and the branch resolution queue.
package bp_pkg;

   localparam int ADDR_W      = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic              pred;
      logic [ADDR_W-1:0] target;
   } pred_entry_t;

endpackage

// File: rtl/branch_resolution_queue_if.sv
// Fetch push, execute resolve and BTB update / redirect signals of the branch resolution queue.
interface branch_resolution_queue_if;
   import bp_pkg::*;

   logic              push_valid;
   logic [ADDR_W-1:0] push_pc;
   logic              push_pred;
   logic [ADDR_W-1:0] push_target;
   logic              full;
   logic              resolve_valid;
   logic              resolve_taken;
   logic [ADDR_W-1:0] resolve_target;
   logic              update_en;
   logic              update_outcome;
   logic [ADDR_W-1:0] update_pc;
   logic [ADDR_W-1:0] update_target;
   logic              mispredict;
   logic [ADDR_W-1:0] redirect_pc;
   logic              underflow;

   modport master (
      output push_valid, push_pc, push_pred, push_target,
      output resolve_valid, resolve_taken, resolve_target,
      input  full, update_en, update_outcome, update_pc, update_target,
      input  mispredict, redirect_pc, underflow
   );

   modport slave (
      input  push_valid, push_pc, push_pred, push_target,
      input  resolve_valid, resolve_taken, resolve_target,
      output full, update_en, update_outcome, update_pc, update_target,
      output mispredict, redirect_pc, underflow
   );

endinterface

// File: rtl/pred_fifo.sv
// Circular FIFO of in-flight predictions; flush empties it and blocks a same-cycle push.
module pred_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  pred_entry_t din,
   output pred_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   pred_entry_t      mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rptr_q];
   // A full queue rejects a push even when a pop frees a slot on the same edge.
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop_ok)  rptr_d = rptr_q + 1'b1;
         if (push_ok && !pop_ok) count_d = count_q + 1'b1;
         if (!push_ok && pop_ok) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/branch_resolution_queue.sv
// Holds predictions until execute resolves them; emits BTB training and mispredict redirects one cycle later.
module branch_resolution_queue
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        clear,
   branch_resolution_queue_if.slave    bus
);

   pred_entry_t       push_ent;
   pred_entry_t       head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_ok;
   logic              mis;

   logic              update_en_q, update_en_d;
   logic              update_outcome_q, update_outcome_d;
   logic [ADDR_W-1:0] update_pc_q, update_pc_d;
   logic [ADDR_W-1:0] update_target_q, update_target_d;
   logic              mispredict_q, mispredict_d;
   logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
   logic              underflow_q, underflow_d;

   assign push_ent = '{pc: bus.push_pc, pred: bus.push_pred, target: bus.push_target};
   assign pop_ok   = bus.resolve_valid && !fifo_empty;
   // Wrong direction, or taken to a different target than predicted.
   assign mis      = pop_ok && ((head.pred != bus.resolve_taken) ||
                                (bus.resolve_taken && (head.target != bus.resolve_target)));

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .clear (clear),
      .push  (bus.push_valid),
      .pop   (bus.resolve_valid),
      .flush (mis),
      .din   (push_ent),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      update_en_d      = pop_ok;
      update_outcome_d = pop_ok && bus.resolve_taken;
      update_pc_d      = pop_ok ? head.pc : update_pc_q;
      update_target_d  = pop_ok ? bus.resolve_target : update_target_q;
      mispredict_d     = mis;
      redirect_pc_d    = redirect_pc_q;
      if (mis) begin
         redirect_pc_d = bus.resolve_taken ? bus.resolve_target
                                           : head.pc + ADDR_W'(INSTR_BYTES);
      end
      underflow_d      = underflow_q || (bus.resolve_valid && fifo_empty);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         update_en_q      <= 1'b0;
         update_outcome_q <= 1'b0;
         update_pc_q      <= '0;
         update_target_q  <= '0;
         mispredict_q     <= 1'b0;
         redirect_pc_q    <= '0;
         underflow_q      <= 1'b0;
      end else begin
         update_en_q      <= update_en_d;
         update_outcome_q <= update_outcome_d;
         update_pc_q      <= update_pc_d;
         update_target_q  <= update_target_d;
         mispredict_q     <= mispredict_d;
         redirect_pc_q    <= redirect_pc_d;
         underflow_q      <= underflow_d;
      end
   end

   assign bus.full           = fifo_full;
   assign bus.update_en      = update_en_q;
   assign bus.update_outcome = update_outcome_q;
   assign bus.update_pc      = update_pc_q;
   assign bus.update_target  = update_target_q;
   assign bus.mispredict     = mispredict_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Bench for branch_resolution_queue: directed scenarios then random traffic against a queue-based model.
module tb_branch_resolution_queue;
   import bp_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic        outcome;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        mis;
      logic [31:0] redir;
   } exp_t;

   logic clk = 1'b0;
   logic clear;
   branch_resolution_queue_if bif ();

   branch_resolution_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   pred_entry_t model_q [$];
   exp_t        exp_q [$];
   logic        m_uf;
   logic [31:0] m_upc, m_utgt, m_redir;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_edge(input logic pv, input logic [31:0] pc, input logic pp,
                             input logic [31:0] pt, input logic rv, input logic rt,
                             input logic [31:0] rtg, input logic clr);
      bit          was_full;
      bit          mis;
      pred_entry_t h;
      exp_t        e;
      if (clr) begin
         model_q.delete();
         m_uf = 1'b0; m_upc = '0; m_utgt = '0; m_redir = '0;
         return;
      end
      was_full = (model_q.size() == DEPTH);
      mis = 1'b0;
      if (rv) begin
         if (model_q.size() == 0) begin
            m_uf = 1'b1;
         end else begin
            h   = model_q.pop_front();
            mis = (h.pred != rt) || (rt && h.target != rtg);
            e.outcome = rt; e.pc = h.pc; e.tgt = rtg; e.mis = mis;
            e.redir   = mis ? (rt ? rtg : h.pc + 32'd4) : m_redir;
            exp_q.push_back(e);
            m_upc = h.pc; m_utgt = rtg; m_redir = e.redir;
            if (mis) model_q.delete();
         end
      end
      if (pv && !was_full && !mis) model_q.push_back('{pc: pc, pred: pp, target: pt});
   endtask

   // One cycle: check state left by the previous edge, then drive inputs for the next edge.
   task automatic step(input logic pv, input logic [31:0] pc, input logic pp, input logic [31:0] pt,
                       input logic rv, input logic rt, input logic [31:0] rtg, input logic clr);
      @(negedge clk);
      check("full",          32'(bif.full),      32'(model_q.size() == DEPTH));
      check("underflow",     32'(bif.underflow), 32'(m_uf));
      check("update_pc_hold", bif.update_pc,     m_upc);
      check("update_tgt_hold", bif.update_target, m_utgt);
      check("redirect_hold", bif.redirect_pc,    m_redir);
      bif.push_valid     = pv;
      bif.push_pc        = pc;
      bif.push_pred      = pp;
      bif.push_target    = pt;
      bif.resolve_valid  = rv;
      bif.resolve_taken  = rt;
      bif.resolve_target = rtg;
      clear              = clr;
      model_edge(pv, pc, pp, pt, rv, rt, rtg, clr);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic push(input logic [31:0] pc, input logic pp, input logic [31:0] pt);
      step(1'b1, pc, pp, pt, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic resolve(input logic rt, input logic [31:0] rtg);
      step(1'b0, '0, 1'b0, '0, 1'b1, rt, rtg, 1'b0);
   endtask

   // Monitor: every update/mispredict pulse must match the oldest expected pop.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bif.update_en || bif.mispredict) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_update: update_en=%0b mispredict=%0b with no pop expected at %0t",
                        bif.update_en, bif.mispredict, $time);
            end else begin
               e = exp_q.pop_front();
               check("update_en",      32'(bif.update_en),      32'd1);
               check("update_outcome", 32'(bif.update_outcome), 32'(e.outcome));
               check("update_pc",      bif.update_pc,           e.pc);
               check("update_target",  bif.update_target,       e.tgt);
               check("mispredict",     32'(bif.mispredict),     32'(e.mis));
               if (e.mis) check("redirect_pc", bif.redirect_pc, e.redir);
            end
         end
      end
   end

   initial begin
      logic [31:0] rpc, rpt, rtg;
      logic        rpv, rpp, rrv, rrt, rclr;
      pred_entry_t h;

      bif.push_valid = 1'b0; bif.push_pc = '0; bif.push_pred = 1'b0; bif.push_target = '0;
      bif.resolve_valid = 1'b0; bif.resolve_taken = 1'b0; bif.resolve_target = '0;
      clear = 1'b1;
      m_uf = 1'b0; m_upc = '0; m_utgt = '0; m_redir = '0;
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      idle();

      // Correct taken prediction
      push(32'h100, 1'b1, 32'h200);
      resolve(1'b1, 32'h200);
      idle();
      // Predicted taken, actually not taken
      push(32'h40, 1'b1, 32'h80);
      resolve(1'b0, 32'h80);
      idle();
      // Taken to the wrong target
      push(32'h10, 1'b1, 32'h20);
      resolve(1'b1, 32'h30);
      idle();
      // Fill, drop a fifth push, drain in order
      for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
      push(32'h2000, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) resolve(1'b0, 32'h0);
      idle();
      // Mispredict on A while D is pushed: B, C, D flushed, next resolve underflows
      push(32'hA0, 1'b0, 32'h0);
      push(32'hB0, 1'b0, 32'h0);
      push(32'hC0, 1'b0, 32'h0);
      step(1'b1, 32'hD0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500, 1'b0);
      resolve(1'b0, 32'h0);
      idle();
      // Same-edge push and resolve on an empty queue is not a bypass
      step(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      resolve(1'b0, 32'h0);
      idle();
      // Fall-through address wraps
      push(32'hFFFF_FFFC, 1'b1, 32'h8);
      resolve(1'b0, 32'h8);
      idle();
      // Clear with entries in flight
      push(32'h700, 1'b1, 32'h800);
      push(32'h704, 1'b0, 32'h0);
      step(1'b1, 32'h708, 1'b0, 32'h0, 1'b1, 1'b1, 32'h800, 1'b1);
      idle();
      idle();

      for (int n = 0; n < 3000; n++) begin
         rclr = ($urandom_range(0, 99) == 0);
         rpv  = ($urandom_range(0, 99) < 55);
         rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         rpp  = 1'($urandom());
         rpt  = 32'h100 * 32'($urandom_range(0, 3));
         rrv  = ($urandom_range(0, 99) < 45);
         rrt  = 1'($urandom());
         rtg  = 32'h100 * 32'($urandom_range(0, 3));
         if (model_q.size() != 0 && $urandom_range(0, 99) < 60) begin
            h   = model_q[0];
            rrt = h.pred;
            if (h.pred) rtg = h.target;
         end
         step(rpv, rpc, rpp, rpt, rrv, rrt, rtg, rclr);
      end
      idle();
      idle();

      @(negedge clk);
      check("pending_updates", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
